control_unit: RTL

- Sequencing controller for the Lab B datapath; it is the master that drives the program counter's Clear and Up inputs.
- Holds the instruction register. Fetches the instruction addressed by the PC from instruction ROM, decodes it, and issues data-memory, register-file and ALU controls for each instruction.
- Sits between instruction ROM, the PC, and the datapath (data RAM, register file, ALU).

---
 rtl/lab_b_pkg.sv | 45 ++++
 rtl/ir_reg.sv | 32 +++
 rtl/control_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lab_b_pkg.sv
// ============================================================================
// Module : lab_b_pkg
// Brief  : Opcodes, state encodings, ALU selects and instruction field positions
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lab_b_pkg;

    typedef logic [3:0] state_t;
    typedef logic [3:0] opcode_t;
    typedef logic [2:0] alu_sel_t;

    localparam opcode_t OP_NOOP  = 4'h0;
    localparam opcode_t OP_STORE = 4'h1;
    localparam opcode_t OP_LOAD  = 4'h2;
    localparam opcode_t OP_ADD   = 4'h3;
    localparam opcode_t OP_SUB   = 4'h4;
    localparam opcode_t OP_HALT  = 4'h5;

    localparam state_t S_INIT   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_LOAD_A = 4'd3;
    localparam state_t S_LOAD_B = 4'd4;
    localparam state_t S_STORE  = 4'd5;
    localparam state_t S_ADD    = 4'd6;
    localparam state_t S_SUB    = 4'd7;
    localparam state_t S_HALT   = 4'd8;

    localparam alu_sel_t ALU_PASS = 3'd0;
    localparam alu_sel_t ALU_ADD  = 3'd1;
    localparam alu_sel_t ALU_SUB  = 3'd2;

    // LSB positions of the 4-bit opcode/register fields and the 8-bit address fields
    localparam int F_OP_LSB     = 12;
    localparam int F_RA_LSB     = 8;
    localparam int F_RB_LSB     = 4;
    localparam int F_RW_LSB     = 0;
    localparam int F_LDADDR_LSB = 4;
    localparam int F_STADDR_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/ir_reg.sv
// ============================================================================
// Module : ir_reg
// Brief  : Load-enabled instruction register with asynchronous clear
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ir_reg #(
    parameter int IW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          IR_ld,
    input  logic [IW-1:0] Instr,
    output logic [IW-1:0] IR
);

    logic [IW-1:0] r_ir;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ir <= '0;
        end else if (IR_ld) begin
            r_ir <= Instr;
        end
    end

    assign IR = r_ir;

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module : control_unit
// Brief  : Fetch/decode/execute sequencer for the Lab B datapath (Moore outputs)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module control_unit
    import lab_b_pkg::*;
#(
    parameter int IW              = 16,
    parameter int DAW             = 8,
    parameter int RAW             = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [IW-1:0]  Instr,
    output logic           PC_clr,
    output logic           PC_up,
    output logic [IW-1:0]  IR,
    output logic [DAW-1:0] D_addr,
    output logic           D_wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_addr,
    output logic           RF_W_en,
    output logic [RAW-1:0] RF_Ra_addr,
    output logic [RAW-1:0] RF_Rb_addr,
    output logic [2:0]     ALU_s0,
    output logic [3:0]     State
);

    state_t  r_state;
    state_t  w_next;
    logic    w_ir_ld;
    opcode_t w_opcode;

    assign w_opcode = IR[F_OP_LSB +: 4];

    ir_reg #(
        .IW (IW)
    ) u_ir_reg (
        .Clock (Clock),
        .Reset (Reset),
        .IR_ld (w_ir_ld),
        .Instr (Instr),
        .IR    (IR)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_NOOP:  w_next = S_FETCH;
                    OP_STORE: w_next = S_STORE;
                    OP_LOAD:  w_next = S_LOAD_A;
                    OP_ADD:   w_next = S_ADD;
                    OP_SUB:   w_next = S_SUB;
                    OP_HALT:  w_next = S_HALT;
                    default:  w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // Outputs depend only on state and IR, so async reset clears them immediately
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        w_ir_ld    = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;
        case (r_state)
            S_INIT: PC_clr = 1'b1;
            S_FETCH: begin
                w_ir_ld = 1'b1;
                PC_up   = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = DAW'(IR[F_LDADDR_LSB +: 8]);
                RF_s      = 1'b1;
                RF_W_addr = RAW'(IR[F_RW_LSB +: 4]);
                RF_W_en   = (r_state == S_LOAD_B);
            end
            S_STORE: begin
                D_addr     = DAW'(IR[F_STADDR_LSB +: 8]);
                RF_Ra_addr = RAW'(IR[F_RA_LSB +: 4]);
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = RAW'(IR[F_RA_LSB +: 4]);
                RF_Rb_addr = RAW'(IR[F_RB_LSB +: 4]);
                ALU_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
                RF_W_addr  = RAW'(IR[F_RW_LSB +: 4]);
                RF_W_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = r_state;

endmodule

`default_nettype wire
